pr4_run_ctrl: RTL and testbench

Parametrised run/dump controller for the single-cycle processor core. It starts the core on request and gates instruction execution one instruction per cycle. It stops on an instruction budget or a halt word, then streams the register file contents out over a valid/ready port. This replaces fixed-delay simulation runs with a deterministic, self-terminating sequence usable in both bench and silicon debug.

---
 rtl/pr4_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_pr4_run_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr4_run_ctrl.sv
// Run/dump controller: gates core execution on an instruction budget or halt word,
// then streams the register file out over valid/ready. PR4_DUMP_NONZERO_EN skips zero registers.
module pr4_run_ctrl #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 32,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int                AW        = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_instr,
    input  logic [DATA_W-1:0] instr,
    output logic              core_en,
    output logic [AW-1:0]     rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AW-1:0]     dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   budget_q, budget_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               halted_q, halted_d;
    logic [AW-1:0]      addr_q, addr_d;

    logic               is_halt;
    logic               at_last;
    logic               skip;

    assign is_halt = (instr == HALT_WORD);
    assign at_last = (addr_q == LAST_ADDR);

`ifdef PR4_DUMP_NONZERO_EN
    // Zero entries are dropped, but the final register always goes out so dump_last ends the stream.
    assign skip = (rf_rdata == '0) && !at_last;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            budget_q  <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            budget_q  <= budget_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            addr_q    <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        budget_d   = budget_q;
        retired_d  = retired_q;
        halted_d   = halted_q;
        addr_d     = addr_q;
        core_en    = 1'b0;
        dump_valid = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    budget_d  = num_instr;
                    retired_d = '0;
                    halted_d  = 1'b0;
                    addr_d    = '0;
                    state_d   = (num_instr == '0) ? ST_DUMP : ST_RUN;
                end
            end

            ST_RUN: begin
                core_en = !is_halt && (retired_q != budget_q);
                // Halt wins over an exhausted budget when both are seen together.
                if (is_halt) begin
                    halted_d = 1'b1;
                    state_d  = ST_DUMP;
                end else if (core_en) begin
                    retired_d = retired_q + CNT_W'(1);
                    if ((retired_q + CNT_W'(1)) == budget_q) begin
                        state_d = ST_DUMP;
                    end
                end else begin
                    state_d = ST_DUMP;
                end
            end

            ST_DUMP: begin
                if (skip) begin
                    addr_d = addr_q + AW'(1);
                end else begin
                    dump_valid = 1'b1;
                    if (dump_ready) begin
                        if (at_last) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rf_raddr  = addr_q;
    assign dump_addr = addr_q;
    assign dump_data = rf_rdata;
    assign dump_last = (state_q == ST_DUMP) && at_last;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DUMP);
    assign done      = (state_q == ST_DONE);
    assign halted    = halted_q;
    assign retired   = retired_q;

    a_dump_stable: assert property (@(posedge clk) disable iff (rst)
        (dump_valid && !dump_ready) |=> (dump_valid && $stable(dump_addr)));

    a_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(core_en && dump_valid));

endmodule

// File: tb/tb_pr4_run_ctrl.sv
// Self-checking bench for pr4_run_ctrl: a small core/register-file model, timing derived
// from budget and halt position, and a beat scoreboard for the dump stream.
module tb_pr4_run_ctrl;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int CW = 16;
  localparam int AW = 5;
  localparam logic [DW-1:0] HALT = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_instr;
  logic [DW-1:0] instr;
  logic          core_en;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          busy;
  logic          done;
  logic          halted;
  logic [CW-1:0] retired;

  logic [DW-1:0] rf [NR];
  logic [DW-1:0] prog [64];
  int pc;

  logic [DW+AW-1:0] exp_q[$];

  int n_tests;
  int n_fail;

  pr4_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_instr(num_instr), .instr(instr),
    .core_en(core_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .done(done),
    .halted(halted), .retired(retired)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];
  assign instr    = prog[pc % 64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_rf(input int mode);
    for (int i = 0; i < NR; i++) begin
      if (mode == 0) rf[i] = $urandom | 32'h1;
      else if (mode == 1) rf[i] = ($urandom_range(0, 3) == 0) ? '0 : ($urandom | 32'h1);
      else rf[i] = '0;
    end
    if (mode == 2) begin
      rf[2] = 32'h0000_00A2;
      rf[7] = 32'h0000_7007;
    end
  endtask

  // driver + per-cycle compare for one complete start..DONE sequence
  task automatic run_one(input int b, input int h_idx, input bit rnd_ready, input int rst_addr);
    int r;
    bit hexp;
    int lead;
    bit lead_open;
    int first_c;
    int c;
    bit started;
    bit finished;
    bit stall_prev;
    bit ce;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic [DW+AW-1:0] e;

    for (int i = 0; i < 64; i++) prog[i] = $urandom & 32'h7FFF_FFFF;
    if (h_idx >= 0) prog[h_idx] = HALT;
    if (h_idx >= 0 && h_idx < b) begin
      r = h_idx;
      hexp = 1'b1;
    end else begin
      r = b;
      hexp = 1'b0;
    end

    exp_q.delete();
    lead = 0;
    lead_open = 1'b1;
    for (int i = 0; i < NR; i++) begin
`ifdef PR4_DUMP_NONZERO_EN
      if (rf[i] != '0 || i == NR - 1) begin
        exp_q.push_back({AW'(i), rf[i]});
        lead_open = 1'b0;
      end else if (lead_open) begin
        lead++;
      end
`else
      exp_q.push_back({AW'(i), rf[i]});
`endif
    end
    first_c = r + 1 + int'(hexp) + lead;

    pc = 0;
    num_instr = CW'(b);
    start = 1'b1;
    dump_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_instr = CW'($urandom);
    c = 1;
    started = 1'b0;
    finished = 1'b0;
    stall_prev = 1'b0;
    p_addr = '0;
    p_data = '0;

    while (!finished && c < 400) begin
      @(negedge clk);
      if (!started) begin
        chk("core_en_run", core_en, c <= r);
        chk("retired_run", retired, (c - 1 < r) ? c - 1 : r);
        chk("dump_valid_timing", dump_valid, c >= first_c);
        chk("busy_run", busy, 1);
        if (c >= first_c) started = 1'b1;
      end
      if (started) begin
        chk("core_en_dump", core_en, 0);
        if (stall_prev) begin
          chk("stall_valid", dump_valid, 1);
          chk("stall_addr", dump_addr, p_addr);
          chk("stall_data", dump_data, p_data);
        end
        if (dump_valid) begin
          chk("dump_last", dump_last, dump_addr == AW'(NR - 1));
          if (rst_addr >= 0 && dump_addr == AW'(rst_addr)) begin
            #2;
            rst = 1'b1;
            #1;
            chk("rst_core_en", core_en, 0);
            chk("rst_dump_valid", dump_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_retired", retired, 0);
            chk("rst_halted", halted, 0);
            chk("rst_dump_addr", dump_addr, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            start = 1'b0;
            dump_ready = 1'b1;
            return;
          end
          if (dump_ready) begin
            if (exp_q.size() == 0) begin
              chk("extra_beat", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("beat_addr", dump_addr, e[DW+:AW]);
              chk("beat_data", dump_data, e[DW-1:0]);
              if (exp_q.size() == 0) finished = 1'b1;
            end
          end
        end
        stall_prev = dump_valid && !dump_ready;
        p_addr = dump_addr;
        p_data = dump_data;
      end
      ce = core_en;
      @(posedge clk);
      #1;
      if (ce) pc++;
      dump_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = (exp_q.size() > 1) && ($urandom_range(0, 5) == 0);
      num_instr = CW'($urandom);
      c++;
    end
    if (!finished) chk("timeout", 0, 1);

    @(negedge clk);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_retired", retired, r);
    chk("end_halted", halted, hexp);
    chk("end_dump_valid", dump_valid, 0);
    chk("end_core_en", core_en, 0);
  endtask

  initial begin
    int b;
    int h;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    num_instr = '0;
    dump_ready = 1'b0;
    pc = 0;
    for (int i = 0; i < 64; i++) prog[i] = '0;
    fill_rf(0);

    #12;
    chk("reset_core_en", core_en, 0);
    chk("reset_dump_valid", dump_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_halted", halted, 0);
    chk("reset_retired", retired, 0);
    chk("reset_dump_addr", dump_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_one(5, -1, 1'b0, -1);
    chk("lit_b5_retired", retired, 5);
    chk("lit_b5_halted", halted, 0);

    run_one(22, 2, 1'b0, -1);
    chk("lit_halt_retired", retired, 2);
    chk("lit_halt_halted", halted, 1);

    run_one(0, 0, 1'b0, -1);
    chk("lit_b0_retired", retired, 0);
    chk("lit_b0_halted", halted, 0);

    run_one(7, -1, 1'b1, -1);

    run_one(4, -1, 1'b1, 10);
    chk("post_rst_idle_done", done, 0);
    run_one(3, -1, 1'b0, -1);
    chk("lit_after_rst_retired", retired, 3);

    fill_rf(2);
    run_one(2, -1, 1'b1, -1);

    for (int k = 0; k < 10; k++) begin
      fill_rf(1);
      b = $urandom_range(0, 40);
      h = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 45) : -1;
      run_one(b, h, $urandom_range(0, 1) == 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
